// File: rtl/xor_stream_checker_if.sv
// xor_stream_checker_if -- bundle of the block-check request, data stream and
// result signals of xor_stream_checker.
//   start/len          : begin a block check of len data words
//   in_valid/in_data   : word stream (data words, then the checksum word)
//   in_ready           : checker accepts a word this cycle
//   busy/done/match    : status, one-cycle done pulse, held result
//   len_err            : block was started with len=0
//   acc                : running XOR accumulator (debug)
// master = stimulus side, slave = checker side.
interface xor_stream_checker_if;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        match;
  logic        len_err;
  logic [31:0] acc;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, busy, done, match, len_err, acc
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, busy, done, match, len_err, acc
  );
endinterface

// File: rtl/xor_stream_checker.sv
// xor_stream_checker -- XOR checksum verifier for a block of len 32-bit words
// followed by one checksum word. The block matches when the XOR of all len+1
// words is zero.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : xor_stream_checker_if.slave (start/len, in_valid/in_data/in_ready,
//           busy, done, match, len_err, acc)
// All outputs are registered; in_ready/busy/done are decoded from the next
// state so they line up with the state register.
module xor_stream_checker (
  input  logic                 clk,
  input  logic                 rst_n,
  xor_stream_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q,    state_d;
  logic [7:0]  cnt_q,      cnt_d;
  logic [31:0] acc_q,      acc_d;
  logic        match_q,    match_d;
  logic        len_err_q,  len_err_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;

  logic        xfer;

  assign xfer = bus.in_valid & in_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    match_d   = match_q;
    len_err_d = len_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          match_d = 1'b0;
          if (bus.len == 8'd0) begin
            // Empty block: report immediately, consume nothing.
            len_err_d = 1'b1;
            state_d   = DONE;
          end else begin
            len_err_d = 1'b0;
            cnt_d     = bus.len;
            acc_d     = '0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          acc_d = acc_q ^ bus.in_data;
          // Saturating decrement so a bad count can never wrap to 255.
          if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = CHECK;
        end
      end
      CHECK: begin
        if (xfer) begin
          match_d = (acc_q == bus.in_data);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == DATA) || (state_d == CHECK);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      match_q    <= 1'b0;
      len_err_q  <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      match_q    <= match_d;
      len_err_q  <= len_err_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.match    = match_q;
  assign bus.len_err  = len_err_q;
  assign bus.acc      = acc_q;

endmodule

// File: tb/tb_xor_stream_checker.sv
// tb_xor_stream_checker -- directed bench for xor_stream_checker.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_xor_stream_checker;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_checks;
  int   cyc;
  int   c0;

  xor_stream_checker_if bus ();

  xor_stream_checker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected run completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [31:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic begin_block(input logic [7:0] l);
    c0        = cyc;
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
    bus.len   = '0;
  endtask

  initial begin
    n_pass       = 0;
    n_checks     = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state, before any clock edge.
    #2;
    chk("rst_busy",     32'(bus.busy),     32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_done",     32'(bus.done),     32'h0);
    chk("rst_match",    32'(bus.match),    32'h0);
    chk("rst_len_err",  32'(bus.len_err),  32'h0);
    chk("rst_acc",      bus.acc,           32'h0);
    chk("rst_cnt",      32'(dut.cnt_q),    32'h0);

    // Release between edges; first start taken on the very next edge.
    #10;
    rst_n = 1'b1;

    // Block 1: len=3, good checksum.
    begin_block(8'd3);
    chk("b1_busy",     32'(bus.busy),     32'h1);
    chk("b1_in_ready", 32'(bus.in_ready), 32'h1);
    chk("b1_cnt",      32'(dut.cnt_q),    32'h3);
    send(32'h0000_00FF);
    send(32'h0000_FF00);
    send(32'h00FF_0000);
    chk("b1_acc_pre",  bus.acc,           32'h00FF_FFFF);
    chk("b1_done_pre", 32'(bus.done),     32'h0);
    send(32'h00FF_FFFF);
    chk("b1_done",     32'(bus.done),     32'h1);
    chk("b1_match",    32'(bus.match),    32'h1);
    chk("b1_acc",      bus.acc,           32'h00FF_FFFF);
    chk("b1_latency",  32'(cyc - c0),     32'd5);
    chk("b1_in_ready_done", 32'(bus.in_ready), 32'h0);
    tick();
    chk("b1_done_pulse", 32'(bus.done),   32'h0);
    chk("b1_busy_end",   32'(bus.busy),   32'h0);
    chk("b1_match_hold", 32'(bus.match),  32'h1);
    chk("b1_acc_hold",   bus.acc,         32'h00FF_FFFF);

    // len=0: immediate done with len_err; a presented word is not consumed.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    begin_block(8'd0);
    chk("l0_done",     32'(bus.done),     32'h1);
    chk("l0_len_err",  32'(bus.len_err),  32'h1);
    chk("l0_match",    32'(bus.match),    32'h0);
    chk("l0_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("l0_in_ready2", 32'(bus.in_ready), 32'h0);
    chk("l0_done_end",  32'(bus.done),     32'h0);
    chk("l0_len_err_hold", 32'(bus.len_err), 32'h1);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Block 2: same data, bad checksum.
    begin_block(8'd3);
    chk("b2_len_err_clr", 32'(bus.len_err), 32'h0);
    send(32'h0000_00FF);
    send(32'h0000_FF00);
    send(32'h00FF_0000);
    send(32'h00FF_FFFE);
    chk("b2_done",  32'(bus.done),  32'h1);
    chk("b2_match", 32'(bus.match), 32'h0);
    chk("b2_acc",   bus.acc,        32'h00FF_FFFF);
    tick();

    // Block 3: len=2 with a 4-cycle in_valid gap.
    begin_block(8'd2);
    send(32'h1111_0000);
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 32'hDEAD_DEAD;  // ignored: in_valid low
      tick();
    end
    chk("gap_acc", bus.acc,         32'h1111_0000);
    chk("gap_cnt", 32'(dut.cnt_q),  32'h1);
    chk("gap_done", 32'(bus.done),  32'h0);
    send(32'h0000_2222);
    send(32'h1111_2222);
    chk("gap_done_end", 32'(bus.done),  32'h1);
    chk("gap_match",    32'(bus.match), 32'h1);
    chk("gap_latency",  32'(cyc - c0),  32'd8);
    tick();

    // Block 4: len=255, all words 0xA5A5_A5A5.
    begin_block(8'd255);
    chk("l255_cnt_start", 32'(dut.cnt_q), 32'd255);
    for (int i = 0; i < 255; i++) send(32'hA5A5_A5A5);
    chk("l255_cnt_end", 32'(dut.cnt_q),   32'h0);
    chk("l255_acc",     bus.acc,          32'hA5A5_A5A5);
    chk("l255_ready",   32'(bus.in_ready), 32'h1);
    send(32'hA5A5_A5A5);
    chk("l255_done",  32'(bus.done),  32'h1);
    chk("l255_match", 32'(bus.match), 32'h1);
    chk("l255_cnt_nowrap", 32'(dut.cnt_q), 32'h0);
    tick();

    // Block 5: reset after 2 of 5 words.
    begin_block(8'd5);
    send(32'h0000_0001);
    send(32'h0000_0002);
    chk("rm_acc_pre", bus.acc, 32'h0000_0003);
    rst_n = 1'b0;
    #1;
    chk("rm_busy",     32'(bus.busy),     32'h0);
    chk("rm_acc",      bus.acc,           32'h0);
    chk("rm_in_ready", 32'(bus.in_ready), 32'h0);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0004;
    tick();
    tick();
    bus.in_valid = 1'b0;
    chk("rm_no_done", 32'(bus.done), 32'h0);
    chk("rm_ignored", bus.acc,       32'h0);
    chk("rm_idle",    32'(bus.busy), 32'h0);
    begin_block(8'd1);
    send(32'h1234_5678);
    send(32'h1234_5678);
    chk("rm_b_done",  32'(bus.done),  32'h1);
    chk("rm_b_match", 32'(bus.match), 32'h1);
    tick();

    // Block 6: start held high (with another len) through DATA and CHECK.
    c0        = cyc;
    bus.start = 1'b1;
    bus.len   = 8'd2;
    tick();
    bus.len   = 8'd7;
    send(32'hDEAD_0000);
    chk("sh_cnt", 32'(dut.cnt_q), 32'h1);
    send(32'h0000_BEEF);
    send(32'hDEAD_BEEF);
    bus.start = 1'b0;
    bus.len   = '0;
    chk("sh_done",    32'(bus.done),  32'h1);
    chk("sh_match",   32'(bus.match), 32'h1);
    chk("sh_acc",     bus.acc,        32'hDEAD_BEEF);
    chk("sh_latency", 32'(cyc - c0),  32'd4);
    tick();
    chk("sh_idle", 32'(bus.busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xor_stream_checker.md
XOR_STREAM_CHECKER -- requirements
Module: xor_stream_checker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n; all state SHALL be clocked on the rising edge of clk.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a block check; sampled only in IDLE
- len  in  8  number of data words in the block; sampled with start
- in_valid  in  1  in_data holds a valid word
- in_data  in  32  data word, or the checksum word after the last data word
- in_ready  out  1  block accepts a word this cycle
- busy  out  1  check in progress (state not IDLE)
- done  out  1  one-cycle pulse: check finished
- match  out  1  result; valid while done=1, held until the next start
- len_err  out  1  start was issued with len=0; valid with done
- acc  out  32  running XOR accumulator, for debug

Function
REQ-003 States SHALL be IDLE, DATA, CHECK and DONE.
REQ-004 A word SHALL transfer only in a cycle where in_valid=1 and in_ready=1; in_data SHALL be ignored in all other cycles.
REQ-005 in_ready SHALL be 1 in DATA and CHECK, and 0 in IDLE and DONE.
REQ-006 IDLE, start=1, len!=0: load cnt=len and acc=0, clear match, go to DATA.
REQ-007 IDLE, start=1, len=0: go to DONE with len_err=1 and match=0; no word is consumed.
REQ-008 DATA, on each transfer: acc <= acc XOR in_data (32-bit bitwise, no carry) and cnt <= cnt-1; when cnt=1 at the transfer, go to CHECK.
REQ-009 CHECK, on a transfer: match <= (acc == in_data), then go to DONE. Equivalently, the result is that the XOR of all len+1 words is zero.
REQ-010 DONE SHALL last exactly one cycle with done=1, then return to IDLE; minimum start-to-done latency is len+2 cycles.
REQ-011 A start asserted outside IDLE SHALL be ignored and SHALL NOT restart or disturb the check in progress.
REQ-012 in_valid=0 in DATA or CHECK SHALL stall with all state held; there is no timeout.
REQ-013 len=255 SHALL be supported with no counter wrap: cnt is 8 bits and only decrements while nonzero.
REQ-014 match and len_err SHALL hold their values after DONE until the next accepted start, which clears both.
REQ-015 acc SHALL hold its final value after DONE until the next accepted start.

Reset
REQ-016 While rst_n=0, regardless of clk: state=IDLE, cnt=0, acc=0, in_ready=0, busy=0, done=0, match=0, len_err=0.
REQ-017 Reset asserted mid-block SHALL abandon the check with no done pulse; after rst_n deasserts, words are ignored until a new start.
REQ-018 The first start SHALL be accepted on the first rising clk edge after rst_n deasserts.

Verification
REQ-019 Directed scenarios the bench SHALL cover:
- len=3; data 0x0000_00FF, 0x0000_FF00, 0x00FF_0000; checksum 0x00FF_FFFF -> done one cycle after checksum transfer, match=1, acc=0x00FF_FFFF.
- Same block with checksum 0x00FF_FFFE -> done pulse, match=0.
- len=0 with start -> done on the next cycle, len_err=1, match=0, in_ready stays 0.
- len=2 with in_valid deasserted for 4 cycles between words -> acc and cnt hold during the gap; final match correct; total latency 8 cycles.
- len=255 with all words 0xA5A5_A5A5, checksum 0xA5A5_A5A5 -> match=1 (odd count of 255); cnt reaches 0 without wrap.
- rst_n pulsed low after 2 of 5 words -> no done, busy=0 and acc=0 immediately; a following len=1 block (0x1234_5678, 0x1234_5678) -> match=1.
- start held high during DATA -> no restart; block result unaffected.
